// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // 64-bit so any WIDTH up to 32 (and MAX_VAL = 2**32-1) fits without overflow.
  function automatic logic [63:0] clamp_max(input logic [63:0] v, input logic [63:0] maxv);
    return (v > maxv) ? maxv : v;
  endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count for one enabled step, with wrap/saturate and boundary events.
module counter_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1,
  parameter longint unsigned STEP    = 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             UpDwn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_ev,
  output logic             unf_ev
);

  // All arithmetic is WIDTH+1 bits so MAX_VAL+1 and count+STEP never truncate.
  localparam logic [WIDTH:0] MAXW  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEPW = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MODW  = MAXW + (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_w;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] res;

  assign cnt_w = {1'b0, count};
  assign sum   = cnt_w + STEPW;

  always_comb begin
    res    = cnt_w;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    case (UpDwn)
      DIR_UP: begin
        if (sum > MAXW) begin
          ovf_ev = 1'b1;
          res    = (sat_mode == MODE_WRAP) ? (sum - MODW) : MAXW;
        end else begin
          res = sum;
        end
      end
      DIR_DN: begin
        if (cnt_w >= STEPW) begin
          res = cnt_w - STEPW;
        end else begin
          unf_ev = 1'b1;
          res    = (sat_mode == MODE_SAT) ? '0 : (cnt_w + MODW - STEPW);
        end
      end
    endcase
  end

  assign next_count = res[WIDTH-1:0];

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter: clr > load > en priority, wrap/saturate, event pulses and sticky flags.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1,
  parameter longint unsigned STEP    = 1,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             UpDwn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] nxt;
  logic             ovf_ev;
  logic             unf_ev;
  logic [WIDTH-1:0] load_clamped;

  counter_step_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_step (
    .count      (count),
    .UpDwn      (UpDwn),
    .sat_mode   (sat_mode),
    .next_count (nxt),
    .ovf_ev     (ovf_ev),
    .unf_ev     (unf_ev)
  );

  assign load_clamped = WIDTH'(clamp_max(64'(load_val), 64'(MAX_VAL)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= RST_W;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else if (clr) begin
      count      <= RST_W;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (en) begin
      // Sticky flags rise on the same edge as the pulse they record.
      count      <= nxt;
      ovf        <= ovf_ev;
      unf        <= unf_ev;
      ovf_sticky <= ovf_sticky | ovf_ev;
      unf_sticky <= unf_sticky | unf_ev;
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end
  end

  assign at_max = (count == MAX_W);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed-vector bench: a default 8-bit counter and a MAX_VAL=9/STEP=3/RST_VAL=4 counter on shared inputs.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       rst, en, updwn, sat_mode, clr, load;
  logic [7:0] load_val;

  logic [7:0] d_count, m_count;
  logic d_ovf, d_unf, d_ovfs, d_unfs, d_atmax, d_atmin;
  logic m_ovf, m_unf, m_ovfs, m_unfs, m_atmax, m_atmin;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  counter_updown_mod u_def (
    .clk(clk), .rst(rst), .en(en), .UpDwn(updwn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val),
    .count(d_count), .ovf(d_ovf), .unf(d_unf), .ovf_sticky(d_ovfs),
    .unf_sticky(d_unfs), .at_max(d_atmax), .at_min(d_atmin)
  );

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .STEP(3), .RST_VAL(4)) u_m9 (
    .clk(clk), .rst(rst), .en(en), .UpDwn(updwn), .sat_mode(sat_mode),
    .clr(clr), .load(load), .load_val(load_val),
    .count(m_count), .ovf(m_ovf), .unf(m_unf), .ovf_sticky(m_ovfs),
    .unf_sticky(m_unfs), .at_max(m_atmax), .at_min(m_atmin)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; updwn = 1'b1; sat_mode = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = 8'd0;
    #12;
    nvec++;
    if ({d_count, d_ovf, d_unf, d_ovfs, d_unfs, d_atmin} !== {8'd0, 4'b0000, 1'b1}) begin
      nerr++;
      $display("FAIL reset_def: got count=%0d flags=%b%b%b%b at_min=%b, want count=0 flags=0000 at_min=1",
               d_count, d_ovf, d_unf, d_ovfs, d_unfs, d_atmin);
    end
    nvec++;
    if ({m_count, m_ovf, m_unf, m_ovfs, m_unfs, m_atmax, m_atmin} !== {8'd4, 6'b000000}) begin
      nerr++;
      $display("FAIL reset_m9: got count=%0d flags=%b%b%b%b at_max=%b at_min=%b, want count=4 all 0",
               m_count, m_ovf, m_unf, m_ovfs, m_unfs, m_atmax, m_atmin);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; updwn = 1'b1;
  endtask

  task automatic test_default_up();
    for (int i = 1; i <= 255; i++) begin
      tick();
      nvec++;
      if (d_count !== 8'(i) || d_ovf !== 1'b0 || d_ovfs !== 1'b0) begin
        nerr++;
        $display("FAIL up_count: got count=%0d ovf=%b sticky=%b, want count=%0d ovf=0 sticky=0",
                 d_count, d_ovf, d_ovfs, i);
      end
    end
    nvec++;
    if (d_atmax !== 1'b1) begin
      nerr++; $display("FAIL up_atmax: got at_max=%b, want 1", d_atmax);
    end
    tick();
    nvec++;
    if (d_count !== 8'd0 || d_ovf !== 1'b1 || d_ovfs !== 1'b1 || d_unf !== 1'b0) begin
      nerr++;
      $display("FAIL up_wrap: got count=%0d ovf=%b sticky=%b unf=%b, want 0 1 1 0",
               d_count, d_ovf, d_ovfs, d_unf);
    end
    tick();
    nvec++;
    if (d_count !== 8'd1 || d_ovf !== 1'b0 || d_ovfs !== 1'b1) begin
      nerr++;
      $display("FAIL up_after_wrap: got count=%0d ovf=%b sticky=%b, want 1 0 1", d_count, d_ovf, d_ovfs);
    end
  endtask

  task automatic test_wrap_m9();
    logic [7:0] exp_c [5] = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
    logic       exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b0; load = 1'b1; load_val = 8'd0; sat_mode = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; updwn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (m_count !== exp_c[i] || m_ovf !== exp_o[i] || m_unf !== 1'b0) begin
        nerr++;
        $display("FAIL wrap_up[%0d]: got count=%0d ovf=%b unf=%b, want count=%0d ovf=%b unf=0",
                 i, m_count, m_ovf, m_unf, exp_c[i], exp_o[i]);
      end
    end
    load = 1'b1; load_val = 8'd2; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; updwn = 1'b0;
    tick();
    nvec++;
    if (m_count !== 8'd9 || m_unf !== 1'b1 || m_unfs !== 1'b1 || m_ovf !== 1'b0 || m_atmax !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_dn: got count=%0d unf=%b unf_sticky=%b ovf=%b at_max=%b, want 9 1 1 0 1",
               m_count, m_unf, m_unfs, m_ovf, m_atmax);
    end
    tick();
    nvec++;
    if (m_count !== 8'd6 || m_unf !== 1'b0 || m_unfs !== 1'b1 || m_ovfs !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_dn2: got count=%0d unf=%b stickies=%b%b, want 6 0 11",
               m_count, m_unf, m_ovfs, m_unfs);
    end
  endtask

  task automatic test_sat_m9();
    logic [7:0] exp_c [3] = '{8'd9, 8'd9, 8'd9};
    logic       exp_o [3] = '{1'b0, 1'b1, 1'b1};
    en = 1'b0; load = 1'b1; load_val = 8'd6; sat_mode = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; updwn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (m_count !== exp_c[i] || m_ovf !== exp_o[i] || m_unf !== 1'b0) begin
        nerr++;
        $display("FAIL sat_up[%0d]: got count=%0d ovf=%b unf=%b, want count=%0d ovf=%b unf=0",
                 i, m_count, m_ovf, m_unf, exp_c[i], exp_o[i]);
      end
    end
    load = 1'b1; load_val = 8'd2; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; updwn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++;
      if (m_count !== 8'd0 || m_unf !== 1'b1 || m_ovf !== 1'b0 || m_atmin !== 1'b1) begin
        nerr++;
        $display("FAIL sat_dn[%0d]: got count=%0d unf=%b ovf=%b at_min=%b, want 0 1 0 1",
                 i, m_count, m_unf, m_ovf, m_atmin);
      end
    end
  endtask

  task automatic test_load_clamp_clr();
    en = 1'b0; load = 1'b1; load_val = 8'd200;
    tick();
    nvec++;
    if (m_count !== 8'd9 || m_atmax !== 1'b1 || m_ovf !== 1'b0 || m_unf !== 1'b0 ||
        m_ovfs !== 1'b1 || m_unfs !== 1'b1) begin
      nerr++;
      $display("FAIL load_clamp: got count=%0d at_max=%b pulses=%b%b stickies=%b%b, want 9 1 00 11",
               m_count, m_atmax, m_ovf, m_unf, m_ovfs, m_unfs);
    end
    nvec++;
    if (d_count !== 8'd200) begin
      nerr++; $display("FAIL load_def: got count=%0d, want 200", d_count);
    end
    // clr with load and a saturating up-step pending: clr must win.
    clr = 1'b1; load = 1'b1; en = 1'b1; updwn = 1'b1; sat_mode = 1'b1;
    tick();
    nvec++;
    if (m_count !== 8'd4 || m_ovf !== 1'b0 || m_unf !== 1'b0 || m_ovfs !== 1'b0 || m_unfs !== 1'b0) begin
      nerr++;
      $display("FAIL clr_wins: got count=%0d flags=%b%b%b%b, want 4 0000",
               m_count, m_ovf, m_unf, m_ovfs, m_unfs);
    end
    nvec++;
    if (d_count !== 8'd0 || d_ovfs !== 1'b0) begin
      nerr++; $display("FAIL clr_def: got count=%0d ovf_sticky=%b, want 0 0", d_count, d_ovfs);
    end
    clr = 1'b0;
  endtask

  task automatic test_load_vs_en_async_rst();
    load = 1'b1; load_val = 8'd255; en = 1'b0; sat_mode = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; updwn = 1'b1;
    tick();
    nvec++;
    if (d_count !== 8'd0 || d_ovf !== 1'b1 || m_count !== 8'd2 || m_ovf !== 1'b1) begin
      nerr++;
      $display("FAIL prep_ovf: got d=%0d/%b m=%0d/%b, want d=0/1 m=2/1", d_count, d_ovf, m_count, m_ovf);
    end
    load = 1'b1; load_val = 8'd7;
    tick();
    nvec++;
    if (d_count !== 8'd7 || m_count !== 8'd7 || d_ovf !== 1'b0 || m_ovf !== 1'b0 || d_ovfs !== 1'b1) begin
      nerr++;
      $display("FAIL load_over_en: got d=%0d m=%0d ovf=%b%b d_sticky=%b, want 7 7 00 1",
               d_count, m_count, d_ovf, m_ovf, d_ovfs);
    end
    #3;
    load_val = 8'd100;
    rst = 1'b1;
    #1;
    nvec++;
    if (d_count !== 8'd0 || m_count !== 8'd4 || {d_ovfs, d_unfs, m_ovfs, m_unfs, d_ovf, m_ovf} !== 6'b0) begin
      nerr++;
      $display("FAIL async_rst: got d=%0d m=%0d flags=%b%b%b%b%b%b, want 0 4 000000",
               d_count, m_count, d_ovfs, d_unfs, m_ovfs, m_unfs, d_ovf, m_ovf);
    end
    tick();
    nvec++;
    if (d_count !== 8'd0 || m_count !== 8'd4) begin
      nerr++; $display("FAIL rst_hold: got d=%0d m=%0d, want 0 4", d_count, m_count);
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_toggle_and_hold();
    load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      updwn = (i % 2 == 0);
      tick();
      nvec++;
      if (d_count !== ((i % 2 == 0) ? 8'd6 : 8'd5) || m_count !== ((i % 2 == 0) ? 8'd8 : 8'd5) ||
          d_ovf !== 1'b0 || d_unf !== 1'b0 || m_ovf !== 1'b0 || m_unf !== 1'b0) begin
        nerr++;
        $display("FAIL toggle[%0d]: got d=%0d m=%0d pulses=%b%b%b%b, want d=%0d m=%0d 0000",
                 i, d_count, m_count, d_ovf, d_unf, m_ovf, m_unf,
                 (i % 2 == 0) ? 6 : 5, (i % 2 == 0) ? 8 : 5);
      end
    end
    en = 1'b0; updwn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (d_count !== 8'd5 || m_count !== 8'd5 || d_ovf !== 1'b0 || m_unf !== 1'b0) begin
        nerr++;
        $display("FAIL hold[%0d]: got d=%0d m=%0d ovf=%b unf=%b, want 5 5 0 0",
                 i, d_count, m_count, d_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_up();
    test_wrap_m9();
    test_sat_m9();
    test_load_clamp_clr();
    test_load_vs_en_async_rst();
    test_toggle_and_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised up/down counter; next generation of the team's 8-bit up/down counter.
- Adds configurable width, modulus and step size.
- Adds runtime wrap/saturate mode, enable, synchronous clear and load.
- Adds per-step overflow/underflow pulses plus sticky flags.
- Used as a general event/position counter in datapath and timing blocks.

Parameters:
- WIDTH, 8: counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1: highest legal count; valid count range is 0..MAX_VAL.
- STEP, 1: increment/decrement per enabled cycle; legal range 1..MAX_VAL.
- RST_VAL, 0: count value on reset and on clr; must be <= MAX_VAL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable.
- UpDwn  in  1  direction; 1 = up, 0 = down.
- sat_mode  in  1  boundary mode; 0 = wrap modulo MAX_VAL+1, 1 = saturate.
- clr  in  1  synchronous clear to RST_VAL; also clears sticky flags.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count (registered).
- ovf  out  1  1-cycle pulse: the up-step just taken crossed MAX_VAL.
- unf  out  1  1-cycle pulse: the down-step just taken crossed 0.
- ovf_sticky  out  1  set by ovf, held until clr or rst.
- unf_sticky  out  1  set by unf, held until clr or rst.
- at_max  out  1  combinational, count == MAX_VAL.
- at_min  out  1  combinational, count == 0.

Behaviour:
- Reset: while rst=1, asynchronously count=RST_VAL and ovf=unf=ovf_sticky=unf_sticky=0. Release takes effect at the next clk edge.
- Priority per edge: clr > load > en. When none is active, count holds and ovf=unf=0.
- clr:
  - count<=RST_VAL.
  - All four flags <=0, including the sticky flags, even if an event would otherwise occur.
- load:
  - count<=min(load_val, MAX_VAL). Values above MAX_VAL clamp to MAX_VAL.
  - ovf=unf=0; sticky flags unchanged.
- en, up (UpDwn=1): compute sum=count+STEP in WIDTH+1 bits; no truncation before compare.
  - sum<=MAX_VAL: count<=sum, ovf=0.
  - sum>MAX_VAL, sat_mode=0: count<=sum-(MAX_VAL+1), ovf=1.
  - sum>MAX_VAL, sat_mode=1: count<=MAX_VAL, ovf=1. Holding at MAX_VAL with en, up asserts ovf every cycle.
- en, down (UpDwn=0):
  - count>=STEP: count<=count-STEP, unf=0.
  - count<STEP, sat_mode=0: count<=count+(MAX_VAL+1)-STEP, unf=1.
  - count<STEP, sat_mode=1: count<=0, unf=1. Holding at 0 with en, down asserts unf every cycle.
- Latency:
  - count, ovf and unf update on the same edge; ovf/unf describe the step just taken.
  - Sticky flags set on that same edge, i.e. sticky rises in the same cycle as the pulse.
- Mode/direction inputs are sampled every edge; a mid-run change takes effect on the next enabled step with no extra cycle.
- ovf and unf are never both 1.
- Reset mid-count overrides everything immediately, including a pending load.
- Arithmetic rule: all intermediates are WIDTH+1 bits, so MAX_VAL=2**WIDTH-1 is safe against overflow.

Decomposition:
- Shared package counter_pkg:
  - Localparams DIR_UP=1'b1, DIR_DN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - A function returning the clamp of a value to MAX_VAL.
- One natural combinational sub-module, counter_step_calc.
  - Inputs: count, UpDwn, sat_mode.
  - Outputs: next_count, ovf_ev, unf_ev.
  - Parameters: WIDTH/MAX_VAL/STEP.
  - The top holds the registers, priority logic and sticky flags.

Test Plan:
- Defaults (WIDTH=8, MAX_VAL=255, STEP=1): rst 15 ns, en=1, UpDwn=1 → count 0,1,2...; at 255 the next edge gives count=0, ovf=1 for one cycle, ovf_sticky=1 thereafter.
- MAX_VAL=9, STEP=3, sat_mode=0, up from 0 → 3,6,9,2 (ovf with 2), 5. Then down from 2 → 9 (unf=1), 6.
- MAX_VAL=9, STEP=3, sat_mode=1:
  - Up from 6 → 9, then 9 with ovf=1; held at 9 → ovf=1 every cycle.
  - Down from 2 → 0 (unf=1), 0 (unf=1).
- load_val=200 with MAX_VAL=9 → count=9, at_max=1, no pulse. Same cycle with clr=1 → count=RST_VAL, stickies cleared (clr wins).
- With en=1 up and load=1 on the same edge, load wins. Assert rst asynchronously mid-cycle, not on an edge → count=RST_VAL and all flags 0 immediately, before the next clk edge.
- Toggle UpDwn every cycle with en=1 from 5 (STEP=1) → 6,5,6,5, no ovf/unf. en=0 for 3 cycles → count frozen, pulses 0.
